// File: rtl/intr_arbiter_if.sv
// MCU-side bus of the interrupt arbiter: IO write/read port, IRQ lines, INT handshake.
// Latency: n/a (signal bundle only).
// Backpressure: none; the MCU strobes are single-cycle pulses with no ready.
// Ports: IRQ/IO_STRB/PORT_ID/OUT_PORT/INT_ACK/INT_DONE flow MCU->arbiter,
//        INT_R/VEC_ID/IN_DATA flow arbiter->MCU.
interface intr_arbiter_if;
  logic [7:0] IRQ;
  logic       IO_STRB;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       INT_ACK;
  logic       INT_DONE;
  logic       INT_R;
  logic [2:0] VEC_ID;
  logic [7:0] IN_DATA;

  modport master (
    output IRQ, IO_STRB, PORT_ID, OUT_PORT, INT_ACK, INT_DONE,
    input  INT_R, VEC_ID, IN_DATA
  );

  modport slave (
    input  IRQ, IO_STRB, PORT_ID, OUT_PORT, INT_ACK, INT_DONE,
    output INT_R, VEC_ID, IN_DATA
  );
endinterface

// File: rtl/intr_arbiter.sv
// Edge-triggered 8-source interrupt arbiter with mask/pending/vector IO registers.
// Latency: IRQ rise -> pend 1 edge, pend -> INT_R 1 more edge; IN_DATA is combinational.
// Backpressure: none; one interrupt in service at a time, new edges keep pending meanwhile.
// Ports: CLK, RESET_N (async active-low), bus (intr_arbiter_if.slave).
module intr_arbiter #(
  parameter logic [7:0] MASK_PORT = 8'h40,
  parameter logic [7:0] PEND_PORT = 8'h41,
  parameter logic [7:0] VEC_PORT  = 8'h42
) (
  input logic           CLK,
  input logic           RESET_N,
  intr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] irq_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] vec_q;

  logic [7:0] irq_edge;
  logic [7:0] active;
  logic [2:0] winner;
  logic       wr_pend, wr_mask;
  logic       ack_take;
  logic [7:0] clr;

  assign irq_edge = bus.IRQ & ~irq_q;
  assign active   = pend_q & mask_q;
  assign wr_pend  = bus.IO_STRB && (bus.PORT_ID == PEND_PORT);
  assign wr_mask  = bus.IO_STRB && (bus.PORT_ID == MASK_PORT);
  // An ACK only counts while something is actually requestable; this also
  // makes it override a clearing write landing in the same cycle.
  assign ack_take = (state_q == ST_REQ) && bus.INT_ACK && (|active);

  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) winner = 3'(i);
    end
  end

  // A rising edge in the same cycle as a clear keeps the bit set.
  always_comb begin
    clr = 8'h00;
    if (wr_pend)  clr = clr | bus.OUT_PORT;
    if (ack_take) clr = clr | (8'h01 << winner);
    pend_d = (pend_q & ~clr) | irq_edge;
    mask_d = wr_mask ? bus.OUT_PORT : mask_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      irq_q   <= 8'h00;
      pend_q  <= 8'h00;
      mask_q  <= 8'h00;
      vec_q   <= 3'd0;
    end else begin
      irq_q  <= bus.IRQ;
      pend_q <= pend_d;
      mask_q <= mask_d;
      case (state_q)
        ST_IDLE: begin
          if (|active) state_q <= ST_REQ;
        end
        ST_REQ: begin
          if (ack_take) begin
            vec_q   <= winner;
            state_q <= ST_SERVICE;
          end else if ((pend_d & mask_d) == 8'h00) begin
            // Withdraw on the same edge that the mask/W1C write empties active.
            state_q <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (bus.INT_DONE) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.INT_R  = (state_q == ST_REQ);
  assign bus.VEC_ID = vec_q;

  always_comb begin
    bus.IN_DATA = 8'h00;
    if (bus.PORT_ID == MASK_PORT)      bus.IN_DATA = mask_q;
    else if (bus.PORT_ID == PEND_PORT) bus.IN_DATA = pend_q;
    else if (bus.PORT_ID == VEC_PORT)  bus.IN_DATA = {5'b00000, vec_q};
  end

endmodule

// File: tb/tb_intr_arbiter.sv
// Testbench for intr_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_intr_arbiter;

  localparam logic [7:0] MP = 8'h40;
  localparam logic [7:0] PP = 8'h41;
  localparam logic [7:0] VP = 8'h42;

  logic CLK;
  logic RESET_N;
  int   total;
  int   bad;

  intr_arbiter_if bus ();

  intr_arbiter #(.MASK_PORT(MP), .PEND_PORT(PP), .VEC_PORT(VP)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: plain integers, state 0=idle 1=requesting 2=in service.
  logic [7:0] m_irq_q, m_pend, m_mask;
  logic [2:0] m_vec;
  int         m_st;

  task automatic model_reset();
    m_irq_q = 8'h00; m_pend = 8'h00; m_mask = 8'h00; m_vec = 3'd0; m_st = 0;
  endtask

  task automatic model_step();
    logic [7:0] rises, clear, act, nmask, npend;
    int win, nst;
    rises = bus.IRQ & ~m_irq_q;
    act   = m_pend & m_mask;
    win   = -1;
    for (int i = 0; i < 8; i++) if (act[i] && win < 0) win = i;
    clear = (bus.IO_STRB && bus.PORT_ID == PP) ? bus.OUT_PORT : 8'h00;
    nmask = (bus.IO_STRB && bus.PORT_ID == MP) ? bus.OUT_PORT : m_mask;
    nst   = m_st;
    if (m_st == 1 && bus.INT_ACK && win >= 0) begin
      clear[win] = 1'b1;
      m_vec = 3'(win);
      nst = 2;
    end
    npend = (m_pend & ~clear) | rises;
    if (m_st == 0 && act != 8'h00) nst = 1;
    if (m_st == 1 && nst == 1 && (npend & nmask) == 8'h00) nst = 0;
    if (m_st == 2 && bus.INT_DONE) nst = 0;
    m_pend = npend; m_mask = nmask; m_irq_q = bus.IRQ; m_st = nst;
  endtask

  function automatic logic [7:0] model_in(input logic [7:0] port);
    if (port == MP) return m_mask;
    if (port == PP) return m_pend;
    if (port == VP) return {5'b00000, m_vec};
    return 8'h00;
  endfunction

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [7:0] port, output logic [7:0] val);
    bus.PORT_ID = port;
    #1;
    val = bus.IN_DATA;
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] data);
    bus.IO_STRB = 1'b1; bus.PORT_ID = port; bus.OUT_PORT = data;
    tick();
    bus.IO_STRB = 1'b0; bus.OUT_PORT = 8'h00;
  endtask

  task automatic pulse_ack();
    bus.INT_ACK = 1'b1; tick(); bus.INT_ACK = 1'b0;
  endtask

  task automatic pulse_done();
    bus.INT_DONE = 1'b1; tick(); bus.INT_DONE = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    RESET_N = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    bus.IRQ = 8'h00; bus.IO_STRB = 1'b0; bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00;
    bus.INT_ACK = 1'b0; bus.INT_DONE = 1'b0;
    RESET_N = 1'b0;
    model_reset();
    #3;
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL reset_intr got=%b want=0", bus.INT_R); end
    total++; if (bus.VEC_ID !== 3'd0) begin bad++; $display("FAIL reset_vec got=%0d want=0", bus.VEC_ID); end
    rd(MP, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_mask got=%h want=00", v); end
    rd(PP, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_pend got=%h want=00", v); end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    rd(8'h43, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL unmapped_port got=%h want=00", v); end
  endtask

  task automatic test_single();
    logic [7:0] v;
    io_write(MP, 8'hFF);
    bus.IRQ = 8'h08;
    tick();
    rd(PP, v);
    total++; if (v !== 8'h08) begin bad++; $display("FAIL single_pend got=%h want=08", v); end
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL single_intr_early got=%b want=0", bus.INT_R); end
    tick();
    total++; if (bus.INT_R !== 1'b1) begin bad++; $display("FAIL single_intr got=%b want=1", bus.INT_R); end
    pulse_ack();
    rd(PP, v);
    total++; if (bus.VEC_ID !== 3'd3) begin bad++; $display("FAIL single_vec got=%0d want=3", bus.VEC_ID); end
    total++; if (v !== 8'h00) begin bad++; $display("FAIL single_pend_clr got=%h want=00", v); end
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL single_intr_ack got=%b want=0", bus.INT_R); end
    rd(VP, v);
    total++; if (v !== 8'h03) begin bad++; $display("FAIL single_vec_port got=%h want=03", v); end
    pulse_done();
    bus.IRQ = 8'h00;
    tick();
  endtask

  task automatic test_priority();
    logic [7:0] v;
    bus.IRQ = 8'h24;
    tick(); tick();
    total++; if (bus.INT_R !== 1'b1) begin bad++; $display("FAIL prio_intr got=%b want=1", bus.INT_R); end
    pulse_ack();
    rd(PP, v);
    total++; if (bus.VEC_ID !== 3'd2) begin bad++; $display("FAIL prio_vec1 got=%0d want=2", bus.VEC_ID); end
    total++; if (v !== 8'h20) begin bad++; $display("FAIL prio_pend got=%h want=20", v); end
    bus.IRQ = 8'h00;
    tick();
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL prio_nonest got=%b want=0", bus.INT_R); end
    pulse_done();
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL prio_idle got=%b want=0", bus.INT_R); end
    tick();
    total++; if (bus.INT_R !== 1'b1) begin bad++; $display("FAIL prio_reassert got=%b want=1", bus.INT_R); end
    pulse_ack();
    total++; if (bus.VEC_ID !== 3'd5) begin bad++; $display("FAIL prio_vec2 got=%0d want=5", bus.VEC_ID); end
    pulse_done();
  endtask

  task automatic test_mask_w1c();
    logic [7:0] v;
    do_reset();
    bus.IRQ = 8'h01;
    tick();
    rd(PP, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL mask_pend got=%h want=01", v); end
    tick(); tick();
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL masked_intr got=%b want=0", bus.INT_R); end
    io_write(MP, 8'h01);
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL unmask_edge1 got=%b want=0", bus.INT_R); end
    tick();
    total++; if (bus.INT_R !== 1'b1) begin bad++; $display("FAIL unmask_edge2 got=%b want=1", bus.INT_R); end
    io_write(PP, 8'hFF);
    rd(PP, v);
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL w1c_intr got=%b want=0", bus.INT_R); end
    total++; if (v !== 8'h00) begin bad++; $display("FAIL w1c_pend got=%h want=00", v); end
    io_write(VP, 8'h55);
    rd(MP, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL vec_write_ignored got=%h want=01", v); end
    bus.IRQ = 8'h00;
    tick();
  endtask

  task automatic test_service_accum();
    logic [7:0] v;
    io_write(MP, 8'hFF);
    bus.IRQ = 8'h10;
    tick(); tick();
    pulse_ack();
    bus.IRQ = 8'h12;
    tick();
    rd(PP, v);
    total++; if (v !== 8'h02) begin bad++; $display("FAIL svc_pend got=%h want=02", v); end
    tick(); tick();
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL svc_hold got=%b want=0", bus.INT_R); end
    pulse_ack();
    total++; if (bus.VEC_ID !== 3'd4) begin bad++; $display("FAIL svc_ack_ignored got=%0d want=4", bus.VEC_ID); end
    pulse_done();
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL svc_done_idle got=%b want=0", bus.INT_R); end
    tick();
    total++; if (bus.INT_R !== 1'b1) begin bad++; $display("FAIL svc_rereq got=%b want=1", bus.INT_R); end
    pulse_ack();
    total++; if (bus.VEC_ID !== 3'd1) begin bad++; $display("FAIL svc_vec got=%0d want=1", bus.VEC_ID); end
    pulse_done();
    bus.IRQ = 8'h00;
    tick();
  endtask

  task automatic test_edge_hold();
    logic [7:0] v;
    bus.IRQ = 8'h80;
    tick(); tick();
    pulse_ack();
    total++; if (bus.VEC_ID !== 3'd7) begin bad++; $display("FAIL hold_vec got=%0d want=7", bus.VEC_ID); end
    pulse_done();
    tick(); tick(); tick();
    rd(PP, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL hold_repend got=%h want=00", v); end
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL hold_intr got=%b want=0", bus.INT_R); end
    bus.IRQ = 8'h00;
    tick();
  endtask

  task automatic test_reset_service();
    logic [7:0] v;
    bus.IRQ = 8'h20;
    tick(); tick();
    pulse_ack();
    total++; if (bus.VEC_ID !== 3'd5) begin bad++; $display("FAIL rsvc_setup got=%0d want=5", bus.VEC_ID); end
    bus.IRQ = 8'h60;
    bus.PORT_ID = MP;
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    v = bus.IN_DATA;
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL rsvc_intr got=%b want=0", bus.INT_R); end
    total++; if (bus.VEC_ID !== 3'd0) begin bad++; $display("FAIL rsvc_vec got=%0d want=0", bus.VEC_ID); end
    total++; if (v !== 8'h00) begin bad++; $display("FAIL rsvc_mask got=%h want=00", v); end
    rd(PP, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL rsvc_pend got=%h want=00", v); end
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    tick();
    rd(PP, v);
    total++; if (v !== 8'h60) begin bad++; $display("FAIL release_pend got=%h want=60", v); end
    total++; if (bus.INT_R !== 1'b0) begin bad++; $display("FAIL release_masked got=%b want=0", bus.INT_R); end
    bus.IRQ = 8'h00;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] ports [4];
    logic [7:0] exp_in;
    ports[0] = MP; ports[1] = PP; ports[2] = VP; ports[3] = 8'h43;
    do_reset();
    io_write(MP, 8'hFF);
    for (int c = 0; c < 3000; c++) begin
      bus.IRQ      = bus.IRQ ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      bus.IO_STRB  = ($urandom_range(0, 5) == 0);
      bus.PORT_ID  = ports[$urandom_range(0, 3)];
      bus.OUT_PORT = 8'($urandom) & 8'($urandom);
      if (bus.IO_STRB && bus.PORT_ID == MP) bus.OUT_PORT = 8'($urandom) | 8'($urandom);
      bus.INT_ACK  = ($urandom_range(0, 2) == 0);
      bus.INT_DONE = ($urandom_range(0, 3) == 0);
      tick();
      exp_in = model_in(bus.PORT_ID);
      total++; if (bus.INT_R !== (m_st == 1)) begin bad++; $display("FAIL rnd_intr cyc=%0d got=%b want=%b", c, bus.INT_R, (m_st == 1)); end
      total++; if (bus.VEC_ID !== m_vec) begin bad++; $display("FAIL rnd_vec cyc=%0d got=%0d want=%0d", c, bus.VEC_ID, m_vec); end
      total++; if (bus.IN_DATA !== exp_in) begin bad++; $display("FAIL rnd_in cyc=%0d port=%h got=%h want=%h", c, bus.PORT_ID, bus.IN_DATA, exp_in); end
    end
    bus.IO_STRB = 1'b0; bus.INT_ACK = 1'b0; bus.INT_DONE = 1'b0; bus.IRQ = 8'h00;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_priority();
    test_mask_w1c();
    test_service_accum();
    test_edge_hold();
    test_reset_service();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
